// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the pipeline request/response handshake and the word-only data
//   memory port of the load/store unit.
//   slave  : view used by load_store_unit (takes requests, drives memory).
//   master : view used by the pipeline/memory side (drives requests, reads
//            responses, returns mem_read_data).
//   Request : req_valid, req_ready, req_store, req_funct3, req_addr, req_wdata
//   Response: resp_valid, resp_rdata, fault_misaligned, fault_illegal
//   Memory  : mem_read, mem_write, mem_address, mem_write_data, mem_read_data
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              fault_misaligned;
    logic              fault_illegal;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, fault_misaligned, fault_illegal,
               mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, fault_misaligned, fault_illegal,
               mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage initiator for RV32I loads and stores against a word-only data
//   memory with an asynchronous read path. One request in flight at a time.
//   Sub-word stores are performed as read-modify-write. Misaligned and
//   illegal-funct3 requests complete without touching memory.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : load_store_unit_if.slave (request, response and memory signals)
//   All response and memory outputs are registered.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCESS    = 3'd1,
        RMW_READ  = 3'd2,
        RMW_WRITE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              fault_mis_q, fault_mis_d;
    logic              fault_ill_q, fault_ill_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

    logic              is_illegal;
    logic              is_misaligned;

    // Pick the lane at byte offset off and extend according to funct3.
    function automatic logic [DATA_W-1:0] extract_load(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] off,
                                                       input logic [2:0] f3);
        logic [DATA_W-1:0] shifted;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'd0:    extract_load = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    extract_load = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    extract_load = {24'd0, shifted[7:0]};
            3'd5:    extract_load = {16'd0, shifted[15:0]};
            default: extract_load = word;
        endcase
    endfunction

    // Replace the byte (f3[0]=0) or halfword (f3[0]=1) lane at off with wdata.
    function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] lane_mask;
        lane_mask   = f3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merge_store = (word & ~(lane_mask << {off, 3'b000}))
                    | ((wdata & lane_mask) << {off, 3'b000});
    endfunction

    // Fault decode works on the live request so a fault can skip straight to RESP.
    always_comb begin
        if (bus.req_store) begin
            is_illegal = (bus.req_funct3 >= 3'd3);
        end else begin
            is_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6)
                       || (bus.req_funct3 == 3'd7);
        end
        is_misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0])
                      || ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d          = state_q;
        store_d          = store_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = '0;
        fault_mis_d      = 1'b0;
        fault_ill_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_address_d    = '0;
        mem_write_data_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (is_illegal || is_misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        fault_ill_d  = is_illegal;
                        fault_mis_d  = !is_illegal;
                    end else if (!bus.req_store || (bus.req_funct3 == 3'd2)) begin
                        state_d          = ACCESS;
                        mem_read_d       = !bus.req_store;
                        mem_write_d      = bus.req_store;
                        mem_address_d    = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_write_data_d = bus.req_store ? bus.req_wdata : '0;
                    end else begin
                        state_d       = RMW_READ;
                        mem_read_d    = 1'b1;
                        mem_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = store_q ? '0 : extract_load(bus.mem_read_data, addr_q[1:0], funct3_q);
            end
            RMW_READ: begin
                // The merged word is built straight from the read data, so no
                // separate capture register is needed.
                state_d          = RMW_WRITE;
                mem_write_d      = 1'b1;
                mem_address_d    = mem_address_q;
                mem_write_data_d = merge_store(bus.mem_read_data, addr_q[1:0], funct3_q, wdata_q);
            end
            RMW_WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            fault_mis_q      <= 1'b0;
            fault_ill_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            fault_mis_q      <= fault_mis_d;
            fault_ill_q      <= fault_ill_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // Request capture is pure data; it is only consumed after an accept.
    always_ff @(posedge clk) begin
        store_q  <= store_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    assign bus.req_ready        = (state_q == IDLE);
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.fault_misaligned = fault_mis_q;
    assign bus.fault_illegal    = fault_ill_q;
    assign bus.mem_read         = mem_read_q;
    assign bus.mem_write        = mem_write_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;

endmodule
